// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
//
// Registered MIPS decode stage sitting between fetch and execute. Each
// accepted instruction word is split into its R/I/J fields and the 12-bit
// datapath control vector, then held in a single output register until
// downstream takes it. MFHI/MFLO are held back at the input until the most
// recent MULTU/DIVU has had MD_LATENCY cycles to produce its result.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. valid, once raised, stays high with its payload stable until ready is
// seen. ready may depend combinationally on the same cycle's inputs.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous discard of the held instruction
//   in_valid/ready    upstream handshake
//   in_instr          32-bit instruction word
//   in_pc_plus4       PC+4 of in_instr
//   out_valid/ready   downstream handshake
//   out_ctrl          {rf_we, sel_wa[1:0], sel_alu_b, sel_result[1:0],
//                      sel_pc[1:0], alu_ctrl[3:0]}
//   out_rs/rt/rd/shamt instruction register fields
//   out_sign_imm      sign-extended immediate
//   out_jump_addr     {pc_plus4[31:28], instr[25:0], 2'b00}
//   out_pc_plus4      registered PC+4
//   out_illegal       opcode/funct not recognised
// ---------------------------------------------------------------------------
module instr_decode_stage #(
    parameter int MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc_plus4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_ctrl,
    output logic [4:0]  out_rs,
    output logic [4:0]  out_rt,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_shamt,
    output logic [31:0] out_sign_imm,
    output logic [31:0] out_jump_addr,
    output logic [31:0] out_pc_plus4,
    output logic        out_illegal
);

    localparam logic [3:0] ALU_MULTU = 4'd7;
    localparam logic [3:0] ALU_DIVU  = 4'd8;

    // ---------------- combinational decode of the incoming word ------------
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [11:0] dec_ctrl;
    logic        dec_illegal;
    logic        in_is_mf;

    assign opcode = in_instr[31:26];
    assign funct  = in_instr[5:0];

    always_comb begin
        dec_ctrl    = 12'h000;
        dec_illegal = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20:   dec_ctrl = 12'hA42;  // ADD
                    6'h22:   dec_ctrl = 12'hA43;  // SUB
                    6'h24:   dec_ctrl = 12'hA44;  // AND
                    6'h25:   dec_ctrl = 12'hA45;  // OR
                    6'h2A:   dec_ctrl = 12'hA46;  // SLT
                    6'h19:   dec_ctrl = 12'h047;  // MULTU
                    6'h1B:   dec_ctrl = 12'h048;  // DIVU
                    6'h10:   dec_ctrl = 12'hA49;  // MFHI
                    6'h12:   dec_ctrl = 12'hA4A;  // MFLO
                    6'h08:   dec_ctrl = 12'h07B;  // JR
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h08:   dec_ctrl = 12'h940;          // ADDI
            6'h23:   dec_ctrl = 12'h900;          // LW
            6'h2B:   dec_ctrl = 12'h140;          // SW
            6'h04:   dec_ctrl = 12'h053;          // BEQ
            6'h02:   dec_ctrl = 12'h060;          // J
            6'h03:   dec_ctrl = 12'hCA0;          // JAL
            default: dec_illegal = 1'b1;
        endcase
    end

    assign in_is_mf = (opcode == 6'h00) && ((funct == 6'h10) || (funct == 6'h12));

    // ---------------- state -------------------------------------------------
    logic        out_valid_q, out_valid_d;
    logic [11:0] ctrl_q;
    logic [4:0]  rs_q, rt_q, rd_q, shamt_q;
    logic [31:0] sign_imm_q, jump_addr_q, pc_plus4_q;
    logic        illegal_q;
    logic [3:0]  md_cnt_q, md_cnt_d;

    logic held_is_md;
    logic md_hold;
    logic accept;
    logic handoff;

    // Only MULTU/DIVU decode to these ALU codes, so the held control vector
    // identifies them without a separate flag.
    assign held_is_md = out_valid_q &&
                        ((ctrl_q[3:0] == ALU_MULTU) || (ctrl_q[3:0] == ALU_DIVU));
    assign md_hold    = (md_cnt_q != 4'd0) || held_is_md;
    assign in_ready   = !flush && (!out_valid_q || out_ready) && !(in_is_mf && md_hold);
    assign accept     = in_valid && in_ready;
    // A flush discards the held word, so it never counts as handed off.
    assign handoff    = out_valid_q && out_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        if (flush)        out_valid_d = 1'b0;
        else if (accept)  out_valid_d = 1'b1;
        else if (handoff) out_valid_d = 1'b0;
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (handoff && held_is_md) md_cnt_d = 4'(MD_LATENCY);
        else if (md_cnt_q != 4'd0) md_cnt_d = md_cnt_q - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            md_cnt_q    <= 4'd0;
        end else begin
            out_valid_q <= out_valid_d;
            md_cnt_q    <= md_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= 12'h000;
            rs_q        <= 5'd0;
            rt_q        <= 5'd0;
            rd_q        <= 5'd0;
            shamt_q     <= 5'd0;
            sign_imm_q  <= 32'd0;
            jump_addr_q <= 32'd0;
            pc_plus4_q  <= 32'd0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            ctrl_q      <= dec_ctrl;
            rs_q        <= in_instr[25:21];
            rt_q        <= in_instr[20:16];
            rd_q        <= in_instr[15:11];
            shamt_q     <= in_instr[10:6];
            sign_imm_q  <= {{16{in_instr[15]}}, in_instr[15:0]};
            jump_addr_q <= {in_pc_plus4[31:28], in_instr[25:0], 2'b00};
            pc_plus4_q  <= in_pc_plus4;
            illegal_q   <= dec_illegal;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_ctrl      = ctrl_q;
    assign out_rs        = rs_q;
    assign out_rt        = rt_q;
    assign out_rd        = rd_q;
    assign out_shamt     = shamt_q;
    assign out_sign_imm  = sign_imm_q;
    assign out_jump_addr = jump_addr_q;
    assign out_pc_plus4  = pc_plus4_q;
    assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

    localparam logic [31:0] I_ADD   = 32'h0022_1820;
    localparam logic [31:0] I_LW    = 32'h8FA8_FFFC;
    localparam logic [31:0] I_JAL   = 32'h0C10_0000;
    localparam logic [31:0] I_SW    = 32'hAC28_0010;
    localparam logic [31:0] I_MULTU = 32'h0022_0019;
    localparam logic [31:0] I_MFHI  = 32'h0000_2810;
    localparam logic [31:0] I_ILL   = 32'hFC00_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc_plus4, out_sign_imm, out_jump_addr, out_pc_plus4;
    logic [11:0] out_ctrl;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;

    instr_decode_stage #(.MD_LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc_plus4(in_pc_plus4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_sign_imm(out_sign_imm),
        .out_jump_addr(out_jump_addr), .out_pc_plus4(out_pc_plus4),
        .out_illegal(out_illegal)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid    = v;
        in_instr    = instr;
        in_pc_plus4 = pc;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #12;
        // reset state
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ctrl", {20'd0, out_ctrl}, 32'd0);
        chk("rst_pc", out_pc_plus4, 32'd0);
        chk("rst_md_cnt", {28'd0, dut.md_cnt_q}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // ADD $3,$1,$2
        out_ready = 1'b1;
        drive(1'b1, I_ADD, 32'h0000_0104);
        #1 chk("add_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_ctrl", {20'd0, out_ctrl}, 32'h A42);
        chk("add_rd", {27'd0, out_rd}, 32'd3);
        chk("add_rs", {27'd0, out_rs}, 32'd1);
        chk("add_rt", {27'd0, out_rt}, 32'd2);
        chk("add_illegal", {31'd0, out_illegal}, 32'd0);
        chk("add_pc", out_pc_plus4, 32'h0000_0104);

        // LW $8,-4($29), back to back
        drive(1'b1, I_LW, 32'h0000_0108);
        tick();
        chk("lw_ctrl", {20'd0, out_ctrl}, 32'h900);
        chk("lw_rt", {27'd0, out_rt}, 32'd8);
        chk("lw_rs", {27'd0, out_rs}, 32'd29);
        chk("lw_imm", out_sign_imm, 32'hFFFF_FFFC);

        // JAL
        drive(1'b1, I_JAL, 32'h4000_0004);
        tick();
        chk("jal_ctrl", {20'd0, out_ctrl}, 32'hCA0);
        chk("jal_jaddr", out_jump_addr, 32'h4040_0000);

        // illegal word
        drive(1'b1, I_ILL, 32'h0000_0200);
        tick();
        chk("ill_valid", {31'd0, out_valid}, 32'd1);
        chk("ill_flag", {31'd0, out_illegal}, 32'd1);
        chk("ill_ctrl", {20'd0, out_ctrl}, 32'h000);

        // ADD then SW with a 3-cycle downstream stall
        drive(1'b1, I_ADD, 32'h0000_0300);
        tick();
        out_ready = 1'b0;
        drive(1'b1, I_SW, 32'h0000_0304);
        #1 chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_ctrl", {20'd0, out_ctrl}, 32'hA42);
            chk("stall_rd", {27'd0, out_rd}, 32'd3);
            chk("stall_pc", out_pc_plus4, 32'h0000_0300);
            chk("stall_in_ready_n", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1 chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("sw_ctrl", {20'd0, out_ctrl}, 32'h140);
        chk("sw_rt", {27'd0, out_rt}, 32'd8);
        chk("sw_imm", out_sign_imm, 32'h0000_0010);
        chk("sw_pc", out_pc_plus4, 32'h0000_0304);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        chk("sw_drained", {31'd0, out_valid}, 32'd0);

        // MULTU followed by MFHI: MFHI held for MD_LATENCY cycles after handoff
        drive(1'b1, I_MULTU, 32'h0000_0400);
        tick();
        chk("multu_ctrl", {20'd0, out_ctrl}, 32'h047);
        drive(1'b1, I_MFHI, 32'h0000_0404);
        #1 chk("mfhi_blk_held", {31'd0, in_ready}, 32'd0);
        tick();  // MULTU handed off here
        chk("multu_gone", {31'd0, out_valid}, 32'd0);
        chk("md_cnt_load", {28'd0, dut.md_cnt_q}, 32'd4);
        chk("mfhi_blk_0", {31'd0, in_ready}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("mfhi_blk_n", {31'd0, in_ready}, 32'd0);
            chk("mfhi_novalid", {31'd0, out_valid}, 32'd0);
        end
        tick();
        chk("mfhi_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("mfhi_valid", {31'd0, out_valid}, 32'd1);
        chk("mfhi_ctrl", {20'd0, out_ctrl}, 32'hA49);
        chk("mfhi_rd", {27'd0, out_rd}, 32'd5);

        // MULTU followed by ADD: no stall
        drive(1'b1, I_MULTU, 32'h0000_0500);
        tick();
        drive(1'b1, I_ADD, 32'h0000_0504);
        #1 chk("add_after_md_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("add_after_md_ctrl", {20'd0, out_ctrl}, 32'hA42);
        chk("add_after_md_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("md_cnt_drained", {28'd0, dut.md_cnt_q}, 32'd0);

        // flush while held
        drive(1'b1, I_ADD, 32'h0000_0600);
        tick();
        out_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, I_SW, 32'h0000_0604);
        #1 chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_no_accept", out_pc_plus4, 32'h0000_0600);

        // flushed MULTU never loads md_cnt
        out_ready = 1'b1;
        drive(1'b1, I_MULTU, 32'h0000_0700);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_md_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_md_cnt", {28'd0, dut.md_cnt_q}, 32'd0);

        // async reset in the middle of a stall with md_cnt running
        drive(1'b1, I_MULTU, 32'h0000_0800);
        tick();
        drive(1'b1, I_ADD, 32'h0000_0804);
        tick();
        out_ready = 1'b0;
        drive(1'b1, I_SW, 32'h0000_0808);
        tick();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_rst_md_cnt", {28'd0, dut.md_cnt_q}, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ctrl", {20'd0, out_ctrl}, 32'd0);
        chk("arst_fields", {12'd0, out_rs, out_rt, out_rd, out_shamt}, 32'd0);
        chk("arst_imm", out_sign_imm, 32'd0);
        chk("arst_jaddr", out_jump_addr, 32'd0);
        chk("arst_pc", out_pc_plus4, 32'd0);
        chk("arst_illegal", {31'd0, out_illegal}, 32'd0);
        chk("arst_md_cnt", {28'd0, dut.md_cnt_q}, 32'd0);
        drive(1'b0, 32'h0, 32'h0);
        #3 rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
